// File: rtl/common_pkg.sv
// Shared types for the operand resolver: addressing modes, register names,
// memory access kinds, resolver states and the auto-increment step sizes.
package common_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    MODE_REG         = 3'd0,
    MODE_REG_DEF     = 3'd1,
    MODE_AUTOINC     = 3'd2,
    MODE_AUTOINC_DEF = 3'd3,
    MODE_AUTODEC     = 3'd4,
    MODE_AUTODEC_DEF = 3'd5,
    MODE_INDEX       = 3'd6,
    MODE_INDEX_DEF   = 3'd7
  } mode_t;

  typedef enum logic [2:0] {
    R0 = 3'd0, R1 = 3'd1, R2 = 3'd2, R3 = 3'd3,
    R4 = 3'd4, R5 = 3'd5, SP = 3'd6, PC = 3'd7
  } reg_t;

  typedef enum logic {
    word_op = 1'b0,
    byte_op = 1'b1
  } op_size;

  typedef enum logic [1:0] {
    INSTRUCTION_FETCH = 2'd0,
    DATA_READ         = 2'd1,
    DATA_WRITE        = 2'd2,
    DATA_RMW          = 2'd3
  } mem_access_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_IDX_RD = 3'd2,
    ST_DEF_RD = 3'd3,
    ST_DONE   = 3'd4
  } res_state_t;

  localparam word_t INC_BYTE = 16'd1;
  localparam word_t INC_WORD = 16'd2;

  // SP and PC must stay word aligned, so byte accesses step them by 2.
  function automatic word_t inc_for(input op_size s, input reg_t r);
    return (s == byte_op && r != SP && r != PC) ? INC_BYTE : INC_WORD;
  endfunction

endpackage

// File: rtl/operand_resolver.sv
// Resolves one operand specifier (mode, register) into an effective address,
// performing register side effects and index/deferred memory reads.
module operand_resolver
  import common_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  mode_t       mode,
  input  reg_t        rsel,
  input  op_size      sz,
  output logic        busy,
  output logic        done,
  output logic        is_reg,
  output word_t       ea,
  output reg_t        reg_rd_idx,
  input  word_t       reg_rd_data,
  output logic        reg_wr_en,
  output reg_t        reg_wr_idx,
  output word_t       reg_wr_data,
  output logic        mem_req,
  output mem_access_t mem_kind,
  output word_t       mem_addr,
  input  logic        mem_ack,
  input  word_t       mem_rdata
);

  res_state_t  state_q, state_d;
  mode_t       mode_q, mode_d;
  reg_t        rsel_q, rsel_d;
  op_size      sz_q, sz_d;
  word_t       ea_q, ea_d;
  logic        is_reg_q, is_reg_d;
  logic        mem_req_q, mem_req_d;
  mem_access_t mem_kind_q, mem_kind_d;
  word_t       mem_addr_q, mem_addr_d;

  logic [WORD_SIZE-1:0] r_val, inc_val, r_plus_inc, r_minus_inc, r_plus2, r_minus2;
  logic [WORD_SIZE-1:0] pc_next, idx_base, idx_sum;
  logic                 ack_ok;
  logic                 index_mode;

  assign r_val       = reg_rd_data;
  assign inc_val     = inc_for(sz_q, rsel_q);
  assign r_plus_inc  = r_val + inc_val;
  assign r_minus_inc = r_val - inc_val;
  assign r_plus2     = r_val + INC_WORD;
  assign r_minus2    = r_val - INC_WORD;
  // During IDX_RD mem_addr_q still holds the PC used for the index fetch.
  assign pc_next     = mem_addr_q + INC_WORD;
  assign idx_base    = (rsel_q == PC) ? pc_next : r_val;
  assign idx_sum     = mem_rdata + idx_base;
  assign ack_ok      = mem_ack && mem_req_q;
  assign index_mode  = (mode_q == MODE_INDEX) || (mode_q == MODE_INDEX_DEF);

  assign reg_rd_idx = (state_q == ST_EXEC && index_mode) ? PC : rsel_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign is_reg     = is_reg_q;
  assign ea         = ea_q;
  assign mem_req    = mem_req_q;
  assign mem_kind   = mem_kind_q;
  assign mem_addr   = mem_addr_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rsel_d      = rsel_q;
    sz_d        = sz_q;
    ea_d        = ea_q;
    is_reg_d    = is_reg_q;
    mem_req_d   = mem_req_q;
    mem_kind_d  = mem_kind_q;
    mem_addr_d  = mem_addr_q;
    reg_wr_en   = 1'b0;
    reg_wr_idx  = rsel_q;
    reg_wr_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          rsel_d  = rsel;
          sz_d    = sz;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (mode_q)
          MODE_REG: begin
            ea_d     = {13'b0, rsel_q};
            is_reg_d = 1'b1;
            state_d  = ST_DONE;
          end
          MODE_REG_DEF: begin
            ea_d    = r_val;
            state_d = ST_DONE;
          end
          MODE_AUTOINC: begin
            ea_d        = r_val;
            reg_wr_en   = 1'b1;
            reg_wr_data = r_plus_inc;
            state_d     = ST_DONE;
          end
          MODE_AUTOINC_DEF: begin
            reg_wr_en   = 1'b1;
            reg_wr_data = r_plus2;
            mem_req_d   = 1'b1;
            mem_kind_d  = DATA_READ;
            mem_addr_d  = r_val;
            state_d     = ST_DEF_RD;
          end
          MODE_AUTODEC: begin
            ea_d        = r_minus_inc;
            reg_wr_en   = 1'b1;
            reg_wr_data = r_minus_inc;
            state_d     = ST_DONE;
          end
          MODE_AUTODEC_DEF: begin
            reg_wr_en   = 1'b1;
            reg_wr_data = r_minus2;
            mem_req_d   = 1'b1;
            mem_kind_d  = DATA_READ;
            mem_addr_d  = r_minus2;
            state_d     = ST_DEF_RD;
          end
          default: begin
            mem_req_d  = 1'b1;
            mem_kind_d = INSTRUCTION_FETCH;
            mem_addr_d = r_val;
            state_d    = ST_IDX_RD;
          end
        endcase
      end
      ST_IDX_RD: begin
        if (ack_ok) begin
          reg_wr_en   = 1'b1;
          reg_wr_idx  = PC;
          reg_wr_data = pc_next;
          if (mode_q == MODE_INDEX) begin
            ea_d      = idx_sum;
            mem_req_d = 1'b0;
            state_d   = ST_DONE;
          end else begin
            // Request stays up: the deferred read follows back to back.
            mem_kind_d = DATA_READ;
            mem_addr_d = idx_sum;
            state_d    = ST_DEF_RD;
          end
        end
      end
      ST_DEF_RD: begin
        if (ack_ok) begin
          ea_d      = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        ea_d     = '0;
        is_reg_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_REG;
      rsel_q     <= R0;
      sz_q       <= word_op;
      ea_q       <= '0;
      is_reg_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_kind_q <= INSTRUCTION_FETCH;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rsel_q     <= rsel_d;
      sz_q       <= sz_d;
      ea_q       <= ea_d;
      is_reg_q   <= is_reg_d;
      mem_req_q  <= mem_req_d;
      mem_kind_q <= mem_kind_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule
